// File: rtl/add_sub_mod_serial.sv
// Limb-serial modular add/subtract: (A+B) mod N or (A-B) mod N.
// Each RUN cycle handles one LIMB_WIDTH slice, LSB first. The block keeps a raw chain and a corrected chain.
module add_sub_mod_serial #(
  parameter int NUM_WIDTH  = 256,
  parameter int LIMB_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op,
  input  logic [NUM_WIDTH-1:0] A,
  input  logic [NUM_WIDTH-1:0] B,
  input  logic [NUM_WIDTH-1:0] N,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_WIDTH-1:0] res
);

  localparam int LIMBS = NUM_WIDTH / LIMB_WIDTH;
  localparam int CNT_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;
  logic   accept, last;

  logic                 op_p0;
  logic [NUM_WIDTH-1:0] a_p0, b_p0, n_p0;
  logic [CNT_W-1:0]     cnt_p0;
  logic                 raw_cy_p0, corr_cy_p0;
  logic [NUM_WIDTH-1:0] raw_p0, corr_p0;

  logic [LIMB_WIDTH-1:0] a_l, b_l, n_l;
  logic [LIMB_WIDTH:0]   raw_ext, corr_ext;
  logic [NUM_WIDTH-1:0]  raw_all, corr_all;
  logic                  sel_corr;
  int                    off;

  assign accept = in_ready & in_valid;
  assign last   = (cnt_p0 == CNT_W'(LIMBS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Limb slice: raw_cy is carry (add) or borrow (sub) of the raw chain, corr_cy is the opposite sense.
  always_comb begin
    off = int'(cnt_p0) * LIMB_WIDTH;
    a_l = a_p0[off +: LIMB_WIDTH];
    b_l = b_p0[off +: LIMB_WIDTH];
    n_l = n_p0[off +: LIMB_WIDTH];
    if (!op_p0) begin
      raw_ext  = {1'b0, a_l} + {1'b0, b_l} + {{LIMB_WIDTH{1'b0}}, raw_cy_p0};
      corr_ext = {1'b0, raw_ext[LIMB_WIDTH-1:0]} - {1'b0, n_l}
                 - {{LIMB_WIDTH{1'b0}}, corr_cy_p0};
      sel_corr = raw_ext[LIMB_WIDTH] | ~corr_ext[LIMB_WIDTH];
    end else begin
      raw_ext  = {1'b0, a_l} - {1'b0, b_l} - {{LIMB_WIDTH{1'b0}}, raw_cy_p0};
      corr_ext = {1'b0, raw_ext[LIMB_WIDTH-1:0]} + {1'b0, n_l}
                 + {{LIMB_WIDTH{1'b0}}, corr_cy_p0};
      sel_corr = raw_ext[LIMB_WIDTH];
    end
    raw_all                      = raw_p0;
    raw_all[off +: LIMB_WIDTH]   = raw_ext[LIMB_WIDTH-1:0];
    corr_all                     = corr_p0;
    corr_all[off +: LIMB_WIDTH]  = corr_ext[LIMB_WIDTH-1:0];
  end

  // The raw carry-out of the top limb lives on in raw_cy_p0, acting as bit NUM_WIDTH of the raw sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_p0      <= 1'b0;
      a_p0       <= '0;
      b_p0       <= '0;
      n_p0       <= '0;
      cnt_p0     <= '0;
      raw_cy_p0  <= 1'b0;
      corr_cy_p0 <= 1'b0;
      raw_p0     <= '0;
      corr_p0    <= '0;
      res        <= '0;
    end else if (accept) begin
      op_p0      <= op;
      a_p0       <= A;
      b_p0       <= B;
      n_p0       <= N;
      cnt_p0     <= '0;
      raw_cy_p0  <= 1'b0;
      corr_cy_p0 <= 1'b0;
    end else if (state == RUN) begin
      cnt_p0     <= last ? '0 : cnt_p0 + 1'b1;
      raw_cy_p0  <= raw_ext[LIMB_WIDTH];
      corr_cy_p0 <= corr_ext[LIMB_WIDTH];
      raw_p0     <= raw_all;
      corr_p0    <= corr_all;
      if (last) res <= sel_corr ? corr_all : raw_all;
    end
  end

endmodule

// File: tb/tb_add_sub_mod_serial.sv
// Directed bench for add_sub_mod_serial (256-bit, 64-bit limbs) with an expected-result queue.
module tb_add_sub_mod_serial;

  localparam int W = 256;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] A, B, N;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;

  logic [W-1:0] exp_q[$];
  int           tests = 0;
  int           fails = 0;

  add_sub_mod_serial #(.NUM_WIDTH(W), .LIMB_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .A(A), .B(B), .N(N), .out_valid(out_valid), .out_ready(out_ready), .res(res)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r = '0;
    for (int i = 0; i < W / 32; i++) r = {r[W-33:0], 32'($urandom)};
    return r;
  endfunction

  function automatic logic [W-1:0] model(input logic o, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [W-1:0] n);
    logic [W:0] s;
    if (!o) begin
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, n}) s = s - {1'b0, n};
    end else begin
      if (a >= b) s = {1'b0, a} - {1'b0, b};
      else        s = {1'b0, a} + {1'b0, n} - {1'b0, b};
    end
    return s[W-1:0];
  endfunction

  // Accepts one request, scrambles the inputs afterwards, waits for DONE and checks latency and result.
  task automatic run_req(input string tag, input logic o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] n, input logic [W-1:0] expv);
    int cyc;
    logic [W-1:0] e;
    check({tag, "_in_ready"}, W'(in_ready), W'(1));
    in_valid = 1'b1; op = o; A = a; B = b; N = n;
    exp_q.push_back(expv);
    tick();
    in_valid = 1'b0; op = ~o; A = rand_word(); B = rand_word(); N = rand_word();
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, W'(cyc), W'(4));
    if (out_valid) begin
      e = exp_q.pop_front();
      check({tag, "_res"}, res, e);
    end
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    check({tag, "_idle_in_ready"}, W'(in_ready), W'(1));
    check({tag, "_idle_out_valid"}, W'(out_valid), W'(0));
  endtask

  initial begin
    logic [W-1:0] held, ra, rb, rn;
    int seen;
    rst = 1'b1; in_valid = 1'b0; op = 1'b0; A = '0; B = '0; N = '0; out_ready = 1'b1;
    #1;
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_res", res, '0);
    tick();
    rst = 1'b0;

    run_req("add97", 1'b0, W'(60), W'(50), W'(97), W'(13));
    drain("add97");
    run_req("add_carry", 1'b0, {192'd0, {64{1'b1}}}, W'(1), {1'b1, 255'd0}, {191'd0, 1'b1, 64'd0});
    drain("add_carry");
    run_req("add_top", 1'b0, {{255{1'b1}}, 1'b0}, {{255{1'b1}}, 1'b0}, {W{1'b1}},
            {{254{1'b1}}, 2'b01});
    drain("add_top");
    run_req("sub_wrap", 1'b1, W'(0), W'(1), W'(97), W'(96));
    drain("sub_wrap");
    run_req("sub_zero", 1'b1, W'(50), W'(50), W'(97), W'(0));
    drain("sub_zero");

    for (int k = 0; k < 4; k++) begin
      rn = rand_word() | W'(1);
      ra = rand_word() % rn;
      rb = rand_word() % rn;
      run_req($sformatf("rand%0d", k), k[0], ra, rb, rn, model(k[0], ra, rb, rn));
      drain($sformatf("rand%0d", k));
    end

    // Backpressure: DONE must hold while out_ready is low.
    out_ready = 1'b0;
    run_req("bp", 1'b0, W'(90), W'(20), W'(97), W'(13));
    held = res;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("bp_valid%0d", i), W'(out_valid), W'(1));
      check($sformatf("bp_in_ready%0d", i), W'(in_ready), W'(0));
      check($sformatf("bp_res%0d", i), res, held);
    end
    drain("bp");
    check("bp_res_retained", res, W'(13));

    // Reset after limb 1 aborts the operation.
    in_valid = 1'b1; op = 1'b0; A = W'(5); B = W'(6); N = W'(97);
    exp_q.push_back(W'(11));
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("abort_in_ready", W'(in_ready), W'(1));
    check("abort_out_valid", W'(out_valid), W'(0));
    check("abort_res", res, '0);
    void'(exp_q.pop_front());
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("abort_no_valid", W'(seen), W'(0));
    run_req("post_abort", 1'b1, W'(10), W'(30), W'(97), W'(77));
    drain("post_abort");
    check("queue_empty", W'(exp_q.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/add_sub_mod_serial.md
ADD_SUB_MOD_SERIAL -- requirements
Module: add_sub_mod_serial

Interface
REQ-001 SHALL have parameter NUM_WIDTH, default 256, operand/result width in bits.
REQ-002 SHALL have parameter LIMB_WIDTH, default 64, bits processed per clock; NUM_WIDTH SHALL be an integer multiple of LIMB_WIDTH; LIMBS = NUM_WIDTH/LIMB_WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op  input  1  0 = modular add, 1 = modular subtract.
REQ-008 A  input  NUM_WIDTH  first operand, 0 <= A < N.
REQ-009 B  input  NUM_WIDTH  second operand, 0 <= B < N.
REQ-010 N  input  NUM_WIDTH  modulus, N > 0.
REQ-011 out_valid  output  1  res holds a finished result.
REQ-012 out_ready  input  1  consumer accepts res.
REQ-013 res  output  NUM_WIDTH  result: (A+B) mod N or (A-B) mod N.

Function
REQ-014 States SHALL be IDLE, RUN, DONE; in_ready = 1 only in IDLE, out_valid = 1 only in DONE.
REQ-015 IDLE: in_valid=1 at a rising edge SHALL latch op, A, B, N, clear limb counter, clear both carry/borrow flags, go to RUN; in_valid=0 stays IDLE.
REQ-016 Inputs A, B, N, op SHALL be ignored outside the accept edge; changes during RUN/DONE SHALL not affect res.
REQ-017 RUN: each cycle SHALL process limb i (i = 0 first, LSB), i = 0..LIMBS-1, advancing counter by 1.
REQ-018 Add per limb: raw_i = A_i + B_i + c_raw; corr_i = raw_i - N_i - b_corr; c_raw/b_corr carried to next limb; both raw and corr limbs stored.
REQ-019 Sub per limb: raw_i = A_i - B_i - b_raw; corr_i = raw_i + N_i + c_corr; both chains carried and stored likewise.
REQ-020 Carry chains SHALL be exact: no bit lost across limb boundaries; final carry-out of raw add chain retained as bit NUM_WIDTH.
REQ-021 On edge processing limb LIMBS-1 SHALL go to DONE and load res: add selects corr iff (c_raw = 1 or b_corr = 0), else raw; sub selects corr iff b_raw = 1, else raw.
REQ-022 Latency: out_valid SHALL rise exactly LIMBS cycles after the accept edge (LIMBS = 1 gives 1 cycle).
REQ-023 DONE: res and out_valid SHALL hold stable while out_ready = 0 (unbounded backpressure).
REQ-024 DONE with out_ready = 1 at edge SHALL return to IDLE; out_valid drops, in_ready rises next cycle; no same-cycle re-accept.
REQ-025 res SHALL retain last result after leaving DONE until the next DONE load.
REQ-026 Throughput: one request per LIMBS+2 cycles maximum with out_ready held 1.
REQ-027 Behaviour for A >= N, B >= N or N = 0 is undefined but SHALL not lock the FSM: DONE is always reached after LIMBS cycles.

Reset
REQ-028 rst=1 SHALL asynchronously force IDLE, in_ready=1, out_valid=0, res=0, counter=0, all carry/borrow flags=0, stored limbs=0.
REQ-029 rst asserted in RUN or DONE SHALL abort the operation; no out_valid pulse for it after release.
REQ-030 First accept SHALL be possible at the first rising edge with rst=0.

Verification (NUM_WIDTH=256, LIMB_WIDTH=64)
REQ-031 Add, N=97, A=60, B=50 -> res=13, out_valid 4 cycles after accept.
REQ-032 Add cross-limb carry, N=2^255, A=2^64-1, B=1 -> res=2^64.
REQ-033 Add top overflow, N=2^256-1, A=B=2^256-2 -> res=2^256-3.
REQ-034 Sub wrap, N=97, A=0, B=1 -> res=96; sub N=97, A=50, B=50 -> res=0.
REQ-035 Backpressure: out_ready=0 for 10 cycles in DONE -> res, out_valid stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-036 rst pulse mid-RUN (after limb 1) -> immediate IDLE, res=0, out_valid never asserted; next request completes correctly.
